// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port arbiter and sequencer in front of the shared byte-addressed data memory.
// Define DMEM_ARB_RR_EN for round-robin tie-breaking; otherwise port 0 has fixed priority.
module dmem_arbiter #(
    parameter logic [31:0] ADDR_LIMIT = 32'd65532
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0,
    input  logic        req1,
    input  logic        we0,
    input  logic        we1,
    input  logic [31:0] addr0,
    input  logic [31:0] addr1,
    input  logic [31:0] wdata0,
    input  logic [31:0] wdata1,
    output logic        gnt0,
    output logic        gnt1,
    output logic        done0,
    output logic        done1,
    output logic        err0,
    output logic        err1,
    output logic [31:0] rdata0,
    output logic [31:0] rdata1,
    output logic [31:0] mem_address,
    output logic [31:0] mem_write_data,
    output logic        mem_memwrite,
    output logic        mem_memread,
    input  logic [31:0] mem_read_data
);
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
    state_t state, state_nx;
    logic win, win_nx, lat_we, err_q, any_req, legal, arb;
    logic [31:0] lat_addr, lat_wdata;

    assign any_req = req0 | req1;
    assign arb = state != ACCESS && any_req;
    assign legal = lat_addr[1:0] == 2'b00 && lat_addr <= ADDR_LIMIT;
    assign mem_address = lat_addr;
    assign mem_write_data = lat_wdata;

`ifdef DMEM_ARB_RR_EN
    logic last_grant;
    assign win_nx = (req0 & req1) ? ~last_grant : req1;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) last_grant <= 1'b1;
        else if (arb) last_grant <= win_nx;
`else
    assign win_nx = ~req0;
`endif

    always_comb begin
        state_nx = (state == ACCESS) ? RESP : (any_req ? ACCESS : IDLE);
        gnt0 = state == ACCESS && !win;
        gnt1 = state == ACCESS && win;
        done0 = state == RESP && !win;
        done1 = state == RESP && win;
        err0 = done0 && err_q;
        err1 = done1 && err_q;
        mem_memwrite = state == ACCESS && legal && lat_we;
        mem_memread = state == ACCESS && legal && !lat_we;
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state <= IDLE;
            win <= 1'b0;
            lat_we <= 1'b0;
            lat_addr <= '0;
            lat_wdata <= '0;
            err_q <= 1'b0;
            rdata0 <= '0;
            rdata1 <= '0;
        end else begin
            state <= state_nx;
            if (arb) begin
                win <= win_nx;
                lat_we <= win_nx ? we1 : we0;
                lat_addr <= win_nx ? addr1 : addr0;
                lat_wdata <= win_nx ? wdata1 : wdata0;
            end
            if (state == ACCESS) err_q <= ~legal;
            if (mem_memread && !win) rdata0 <= mem_read_data;
            if (mem_memread && win) rdata1 <= mem_read_data;
        end
endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter and sequencer in front of the shared byte-addressed data memory (64 KiB, big-endian 32-bit words, synchronous write, combinational read). It accepts word requests from two requesters (port 0: load/store unit, port 1: DMA/debug loader), selects one per transaction, and drives the memory's address/write-data/memwrite/memread pins. It returns a registered read word and a completion pulse to the winner. Misaligned or out-of-range accesses are rejected without touching memory.

## Interface
Parameters:
- ADDR_LIMIT, 32'd65532: highest legal word address; any greater address is an error.

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst_n  input  1  asynchronous, active-low reset.
- req0, req1  input  1  request from port 0/1; held high until the matching gnt.
- we0, we1  input  1  1 = write, 0 = read; valid while req high.
- addr0, addr1  input  32  byte address; valid while req high.
- wdata0, wdata1  input  32  write word; valid while req high.
- gnt0, gnt1  output  1  one-cycle pulse: request latched, access in progress.
- done0, done1  output  1  one-cycle pulse: access complete.
- err0, err1  output  1  pulses with done when the access was rejected.
- rdata0, rdata1  output  32  last read word for the port; held until that port's next successful read.
- mem_address  output  32  to memory address.
- mem_write_data  output  32  to memory write_data.
- mem_memwrite  output  1  to memory memwrite.
- mem_memread  output  1  to memory memread.
- mem_read_data  input  32  from memory read_data.

## Operation
- FSM states: IDLE, ACCESS, RESP. Reset state: IDLE.
- IDLE or RESP: if any req is high, pick a winner, latch its we/addr/wdata and the winner id, go to ACCESS; otherwise go to IDLE.
- ACCESS: gnt of the winner = 1. If the latched address is legal (addr[1:0]==0 and addr<=ADDR_LIMIT), drive mem_address=latched addr and mem_memwrite=we or mem_memread=~we. Write commits at the closing edge; read data is captured into rdata of the winner at that edge. If the address is illegal, memwrite and memread stay 0 and the error flag is latched. Always go to RESP.
- RESP: done of the winner = 1, and err = latched error flag. Arbitration runs in the same cycle.
- req is ignored in ACCESS. A requester must deassert req at the edge ending its gnt cycle. If req is still high in RESP, it counts as a new request.
- Outside ACCESS: mem_memwrite = mem_memread = 0, and mem_address/mem_write_data hold their last latched values.
- Winner selection: see Configuration. The last_grant register updates on each IDLE/RESP→ACCESS transition.
- Reset values: all gnt/done/err = 0, rdata0/rdata1 = 0, mem_* outputs = 0, last_grant = 1 (so port 0 wins the first tie).

## Timing
- Request sampled high at edge k (IDLE) → gnt in cycle k..k+1 (ACCESS) → done and rdata valid in cycle k+1..k+2 (RESP).
- Latency is 2 cycles from the sampling edge to done.
- Sustained throughput is 1 access per 2 cycles (RESP→ACCESS back-to-back).
- Simultaneous req0 and req1 → exactly one gnt. The loser keeps req high and is served in the next arbitration (round-robin build).
- rdata of a port updates only at the end of that port's legal read ACCESS; writes and errors leave it unchanged.
- Asynchronous reset during ACCESS drops mem_memwrite immediately, so no write commits if rst_n is low at the edge. No done is issued for the aborted transaction.
- gnt and done never assert in the same cycle for the same port.

## Configuration
- DMEM_ARB_RR_EN defined: round-robin. On a tie, the port not in last_grant wins. A single requester always wins.
- DMEM_ARB_RR_EN undefined: fixed priority, port 0 always wins ties. Port 1 can starve; the last_grant register is not synthesized.

## Test plan
- Single read: memory word at 0x10 = 0xDEADBEEF; req0 read addr 0x10 at edge 1 → gnt0 in cycle 1, done0 in cycle 2, rdata0 = 0xDEADBEEF, err0 = 0.
- Write then read: port 1 writes 0x12345678 to 0x20, then reads 0x20 → done1 twice, rdata1 = 0x12345678; bytes 0x20..0x23 = 12,34,56,78.
- Tie (RR build): req0 and req1 held continuously → grants alternate 0,1,0,1 starting with 0, one done every 2 cycles. Fixed build: port 0 is granted every time.
- Errors: read at 0x22, then write at 0x10000 → err pulses with done in both cases, mem_memwrite/mem_memread never assert, rdata unchanged, memory unchanged.
- Reset mid-write: assert rst_n=0 during ACCESS of a write of 0xFFFFFFFF to 0x30 → target bytes unchanged; all outputs read 0 while reset is held; the first request after release gets its gnt 1 cycle after sampling.
- Back-to-back: req0 kept high across RESP → a second gnt0 in the cycle immediately after done0 (no IDLE cycle).
